// File: rtl/t5_pkg.sv
// Shared t5 pipeline constants: opcodes, X-stage strobe encoding, LSU states.
package t5_pkg;

    localparam logic [4:0] OPC_LOAD  = 5'b00000;
    localparam logic [4:0] OPC_STORE = 5'b01000;
    localparam logic [4:0] OPC_NOP   = 5'b00100;

    localparam logic [1:0] XSTB_ALU = 2'b00;
    localparam logic [1:0] XSTB_LD  = 2'b01;
    localparam logic [1:0] XSTB_ST  = 2'b10;
    localparam logic [1:0] XSTB_NOP = 2'b11;

    // funct3[13:12] access size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_DONE = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/t5_lane.sv
// Byte-lane select, store-data replication and misalignment detect for a
// 32-bit access; purely combinational so fetch-side alignment can reuse it.
module t5_lane
    import t5_pkg::*;
(
    input  logic [1:0]  a_i,
    input  logic [1:0]  fn3_i,
    input  logic [31:0] rs2_i,
    output logic [3:0]  sel_o,
    output logic [31:0] dto_o,
    output logic        mis_o
);

    always_comb begin
        sel_o = 4'hF;
        dto_o = rs2_i;
        mis_o = 1'b0;
        case (fn3_i)
            SZ_BYTE: begin
                sel_o = 4'b0001 << a_i;
                dto_o = {4{rs2_i[7:0]}};
            end
            SZ_HALF: begin
                sel_o = a_i[1] ? 4'hC : 4'h3;
                dto_o = {2{rs2_i[15:0]}};
                mis_o = a_i[0];
            end
            default: begin
                mis_o = |a_i;
            end
        endcase
    end

endmodule

// File: rtl/t5_lsu.sv
// Execute-stage load/store unit: registers EA/lanes/store data at D->X and
// runs the Wishbone data cycle, stalling the pipe until acknowledge.
module t5_lsu
    import t5_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            sena,
    input  logic [6:2]      dopc,
    input  logic [14:12]    dfn3,
    input  logic            dkil,
    input  logic [XLEN-1:0] drs1,
    input  logic [XLEN-1:0] drs2,
    input  logic [XLEN-1:0] dimm,
    input  logic            dwb_ack,
    input  logic [XLEN-1:0] dwb_dti,
    output logic [31:2]     dwb_adr,
    output logic [XLEN-1:0] dwb_dto,
    output logic [3:0]      dwb_sel,
    output logic            dwb_cyc,
    output logic            dwb_stb,
    output logic            dwb_wre,
    output logic [XLEN-1:0] dwb_dtm,
    output logic [6:2]      xopc,
    output logic [14:12]    xfn3,
    output logic [3:0]      xsel,
    output logic [1:0]      xstb,
    output logic            xmis,
    output logic            dstl
);

    logic [XLEN-1:0] ea_d;
    logic [3:0]      sel_d;
    logic [XLEN-1:0] dto_d;
    logic            lane_mis;
    logic            is_ld, is_st, mis_d;
    logic [1:0]      xstb_d;

    logic [6:2]      xopc_q;
    logic [14:12]    xfn3_q;
    logic [3:0]      xsel_q;
    logic [1:0]      xstb_q;
    logic            xmis_q;
    logic [31:2]     xadr_q;
    logic [XLEN-1:0] dto_q;
    logic [XLEN-1:0] hold_q;
    lsu_state_e      state_q;
    logic            mem;

    assign ea_d = drs1 + dimm;

    t5_lane u_lane (
        .a_i   (ea_d[1:0]),
        .fn3_i (dfn3[13:12]),
        .rs2_i (drs2),
        .sel_o (sel_d),
        .dto_o (dto_d),
        .mis_o (lane_mis)
    );

    assign is_ld = (dopc == OPC_LOAD);
    assign is_st = (dopc == OPC_STORE);
    // ALU ops reuse funct3 for other purposes, so alignment only matters for memory ops
    assign mis_d = lane_mis & (is_ld | is_st);

    always_comb begin
        xstb_d = XSTB_ALU;
        if (dkil || mis_d) xstb_d = XSTB_NOP;
        else if (is_ld)    xstb_d = XSTB_LD;
        else if (is_st)    xstb_d = XSTB_ST;
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            xopc_q  <= OPC_NOP;
            xfn3_q  <= '0;
            xsel_q  <= 4'hF;
            xstb_q  <= XSTB_NOP;
            xmis_q  <= 1'b0;
            xadr_q  <= '0;
            dto_q   <= '0;
            hold_q  <= '0;
            state_q <= LSU_IDLE;
        end else begin
            if (sena) begin
                xopc_q <= dopc;
                xfn3_q <= dfn3;
                xsel_q <= sel_d;
                xstb_q <= xstb_d;
                xmis_q <= mis_d;
                xadr_q <= ea_d[31:2];
                dto_q  <= dto_d;
            end
            // DONE parks an ack taken while another unit stalls the pipe
            case (state_q)
                LSU_IDLE: if (mem && dwb_ack && !sena) begin
                    state_q <= LSU_DONE;
                    hold_q  <= dwb_dti;
                end
                LSU_DONE: if (sena) state_q <= LSU_IDLE;
                default:  state_q <= LSU_IDLE;
            endcase
        end
    end

    assign mem     = (xstb_q == XSTB_LD) || (xstb_q == XSTB_ST);
    assign dwb_cyc = mem && (state_q == LSU_IDLE);
    assign dwb_stb = dwb_cyc;
    assign dwb_wre = (xstb_q == XSTB_ST);
    assign dwb_adr = xadr_q;
    assign dwb_sel = xsel_q;
    assign dwb_dto = dto_q;
    assign dwb_dtm = (state_q == LSU_DONE) ? hold_q : dwb_dti;
    assign dstl    = dwb_cyc && !dwb_ack;

    assign xopc = xopc_q;
    assign xfn3 = xfn3_q;
    assign xsel = xsel_q;
    assign xstb = xstb_q;
    assign xmis = xmis_q;

endmodule

// File: tb/tb_t5_lsu.sv
// Directed bench for t5_lsu: a vector table for X-register formation plus
// hand-written bus sequences for wait states, external stalls, kill and reset.
module tb_t5_lsu;

    logic        sclk, srst, sena, dkil, dwb_ack;
    logic [6:2]  dopc;
    logic [14:12] dfn3;
    logic [31:0] drs1, drs2, dimm, dwb_dti;
    logic [31:2] dwb_adr;
    logic [31:0] dwb_dto, dwb_dtm;
    logic [3:0]  dwb_sel, xsel;
    logic        dwb_cyc, dwb_stb, dwb_wre, xmis, dstl;
    logic [6:2]  xopc;
    logic [14:12] xfn3;
    logic [1:0]  xstb;

    int n_cmp = 0;
    int n_bad = 0;

    t5_lsu #(.XLEN(32)) dut (
        .sclk(sclk), .srst(srst), .sena(sena), .dopc(dopc), .dfn3(dfn3),
        .dkil(dkil), .drs1(drs1), .drs2(drs2), .dimm(dimm),
        .dwb_ack(dwb_ack), .dwb_dti(dwb_dti), .dwb_adr(dwb_adr),
        .dwb_dto(dwb_dto), .dwb_sel(dwb_sel), .dwb_cyc(dwb_cyc),
        .dwb_stb(dwb_stb), .dwb_wre(dwb_wre), .dwb_dtm(dwb_dtm),
        .xopc(xopc), .xfn3(xfn3), .xsel(xsel), .xstb(xstb), .xmis(xmis),
        .dstl(dstl)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    typedef struct {
        logic [4:0]  opc;
        logic [2:0]  fn3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        kil;
        logic [29:0] e_adr;
        logic [3:0]  e_sel;
        logic [31:0] e_dto;
        logic [1:0]  e_stb;
        logic        e_mis;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] opc, input logic [2:0] fn3, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic kil);
        dopc = opc; dfn3 = fn3; drs1 = rs1; drs2 = rs2; dimm = imm; dkil = kil;
    endtask

    task automatic set_nop();
        set_d(5'b00100, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        logic exp_mem;
        int   hi;

        // opc, fn3, rs1, rs2, imm, kil | adr, sel, dto, xstb, xmis
        tv[0] = '{5'b00000, 3'b000, 32'h1000,     32'h11223344, 32'h3,        1'b0, 30'h400,  4'h8, 32'h44444444, 2'b01, 1'b0}; // LB
        tv[1] = '{5'b01000, 3'b001, 32'h2000,     32'hABCD1234, 32'h2,        1'b0, 30'h800,  4'hC, 32'h12341234, 2'b10, 1'b0}; // SH
        tv[2] = '{5'b00000, 3'b010, 32'h3000,     32'hCAFEF00D, 32'h1,        1'b0, 30'hC00,  4'hF, 32'hCAFEF00D, 2'b11, 1'b1}; // LW mis
        tv[3] = '{5'b01000, 3'b000, 32'h4000,     32'h000000A5, 32'h1,        1'b1, 30'h1000, 4'h2, 32'hA5A5A5A5, 2'b11, 1'b0}; // SB kill
        tv[4] = '{5'b00100, 3'b001, 32'h1,        32'h0000BEEF, 32'h0,        1'b0, 30'h0,    4'h3, 32'hBEEFBEEF, 2'b00, 1'b0}; // ALU odd
        tv[5] = '{5'b00000, 3'b001, 32'hFFFFFFFF, 32'h0,        32'h3,        1'b0, 30'h0,    4'hC, 32'h0,        2'b01, 1'b0}; // LH wrap
        tv[6] = '{5'b01000, 3'b010, 32'h100,      32'h01020304, 32'hFFFFFFFC, 1'b0, 30'h3F,   4'hF, 32'h01020304, 2'b10, 1'b0}; // SW
        tv[7] = '{5'b00000, 3'b100, 32'h10,       32'h000000FF, 32'h2,        1'b0, 30'h4,    4'h4, 32'hFFFFFFFF, 2'b01, 1'b0}; // LBU
        tv[8] = '{5'b01000, 3'b001, 32'h0,        32'h00007777, 32'h3,        1'b0, 30'h0,    4'hC, 32'h77777777, 2'b11, 1'b1}; // SH mis
        tv[9] = '{5'b00000, 3'b010, 32'h1000,     32'h0,        32'h2,        1'b0, 30'h400,  4'hF, 32'h0,        2'b11, 1'b1}; // LW a=2

        srst = 1'b1; sena = 1'b1; dwb_ack = 1'b0; dwb_dti = 32'h55;
        set_d(5'b00000, 3'b010, 32'h1234, 32'h5678, 32'h0, 1'b0);
        tick(); tick();

        // reset state
        chk("rst_xopc", 32'(xopc), 32'h04);
        chk("rst_xfn3", 32'(xfn3), 32'h0);
        chk("rst_xsel", 32'(xsel), 32'hF);
        chk("rst_xstb", 32'(xstb), 32'h3);
        chk("rst_xmis", 32'(xmis), 32'h0);
        chk("rst_dto",  dwb_dto,   32'h0);
        chk("rst_adr",  32'(dwb_adr), 32'h0);
        chk("rst_cyc",  {29'h0, dwb_cyc, dwb_stb, dwb_wre}, 32'h0);
        chk("rst_dstl", 32'(dstl), 32'h0);
        chk("rst_dtm",  dwb_dtm,   32'h55);
        srst = 1'b0;

        // X-register formation table; ack held low so dstl mirrors the request
        for (int i = 0; i < 10; i++) begin
            set_d(tv[i].opc, tv[i].fn3, tv[i].rs1, tv[i].rs2, tv[i].imm, tv[i].kil);
            sena = 1'b1; dwb_ack = 1'b0;
            tick();
            exp_mem = (tv[i].e_stb == 2'b01) || (tv[i].e_stb == 2'b10);
            chk($sformatf("v%0d_adr", i),  32'(dwb_adr), 32'(tv[i].e_adr));
            chk($sformatf("v%0d_sel", i),  32'(dwb_sel), 32'(tv[i].e_sel));
            chk($sformatf("v%0d_xsel", i), 32'(xsel),    32'(tv[i].e_sel));
            chk($sformatf("v%0d_dto", i),  dwb_dto,      tv[i].e_dto);
            chk($sformatf("v%0d_xstb", i), 32'(xstb),    32'(tv[i].e_stb));
            chk($sformatf("v%0d_xmis", i), 32'(xmis),    32'(tv[i].e_mis));
            chk($sformatf("v%0d_wre", i),  32'(dwb_wre), 32'(tv[i].e_stb == 2'b10));
            chk($sformatf("v%0d_cyc", i),  {30'h0, dwb_cyc, dwb_stb}, exp_mem ? 32'h3 : 32'h0);
            chk($sformatf("v%0d_dstl", i), 32'(dstl),    32'(exp_mem));
            chk($sformatf("v%0d_xopc", i), 32'(xopc),    32'(tv[i].opc));
            chk($sformatf("v%0d_xfn3", i), 32'(xfn3),    32'(tv[i].fn3));
        end

        // LB zero-wait, then back-to-back SW with no dead cycle
        set_d(5'b00000, 3'b000, 32'h1000, 32'h0, 32'h3, 1'b0);
        sena = 1'b1; dwb_ack = 1'b0;
        tick();
        dwb_ack = 1'b1; dwb_dti = 32'h80000000;
        set_d(5'b01000, 3'b010, 32'h40, 32'h900DF00D, 32'h0, 1'b0);
        #1;
        chk("lb_stb",  32'(dwb_stb), 32'h1);
        chk("lb_adr",  32'(dwb_adr), 32'h400);
        chk("lb_dstl", 32'(dstl),    32'h0);
        chk("lb_dtm",  dwb_dtm,      32'h80000000);
        tick();
        dwb_ack = 1'b0; set_nop();
        #1;
        chk("b2b_stb", 32'(dwb_stb), 32'h1);
        chk("b2b_wre", 32'(dwb_wre), 32'h1);
        chk("b2b_adr", 32'(dwb_adr), 32'h10);
        dwb_ack = 1'b1;
        tick();
        dwb_ack = 1'b0;
        #1;
        chk("b2b_idle", 32'(dwb_stb), 32'h0);

        // SH with 3 wait cycles; hazard unit holds sena low while dstl
        set_d(5'b01000, 3'b001, 32'h2000, 32'hABCD1234, 32'h2, 1'b0);
        sena = 1'b1;
        tick();
        hi = 0;
        for (int w = 0; w < 3; w++) begin
            sena = 1'b0; dwb_ack = 1'b0;
            #1;
            if (dstl) hi++;
            chk($sformatf("sh_w%0d_stb", w), 32'(dwb_stb), 32'h1);
            chk($sformatf("sh_w%0d_adr", w), 32'(dwb_adr), 32'h800);
            chk($sformatf("sh_w%0d_sel", w), 32'(dwb_sel), 32'hC);
            chk($sformatf("sh_w%0d_dto", w), dwb_dto,      32'h12341234);
            tick();
        end
        dwb_ack = 1'b1; sena = 1'b1; set_nop();
        #1;
        chk("sh_ack_dstl", 32'(dstl), 32'h0);
        chk("sh_wre",      32'(dwb_wre), 32'h1);
        chk("sh_stl_cnt",  32'(hi), 32'd3);
        tick();
        dwb_ack = 1'b0;
        #1;
        chk("sh_done_stb", 32'(dwb_stb), 32'h0);

        // ack while another unit holds sena low
        set_d(5'b00000, 3'b010, 32'h6000, 32'h0, 32'h0, 1'b0);
        sena = 1'b1;
        tick();
        sena = 1'b0; dwb_ack = 1'b1; dwb_dti = 32'hDEADBEEF;
        #1;
        chk("xs_ack_dtm", dwb_dtm, 32'hDEADBEEF);
        tick();
        for (int k = 0; k < 2; k++) begin
            dwb_ack = 1'b0; dwb_dti = 32'h12345678 + k;
            #1;
            chk($sformatf("xs_h%0d_stb", k),  32'(dwb_stb), 32'h0);
            chk($sformatf("xs_h%0d_cyc", k),  32'(dwb_cyc), 32'h0);
            chk($sformatf("xs_h%0d_dstl", k), 32'(dstl),    32'h0);
            chk($sformatf("xs_h%0d_dtm", k),  dwb_dtm,      32'hDEADBEEF);
            tick();
        end
        sena = 1'b1; set_nop();
        tick();
        dwb_dti = 32'h0BADCAFE;
        #1;
        chk("xs_idle_dtm", dwb_dtm, 32'h0BADCAFE);
        chk("xs_idle_stb", 32'(dwb_stb), 32'h0);

        // dkil with sena low is ignored; X keeps the ALU op
        set_d(5'b00000, 3'b010, 32'h100, 32'h0, 32'h0, 1'b1);
        sena = 1'b0;
        tick();
        chk("kl_lo_xstb", 32'(xstb), 32'h0);
        chk("kl_lo_xopc", 32'(xopc), 32'h04);
        dkil = 1'b0; sena = 1'b1;
        tick();
        chk("kl_hi_xstb", 32'(xstb), 32'h1);
        dwb_ack = 1'b1; set_nop();
        tick();
        dwb_ack = 1'b0;

        // reset while a load waits for ack
        set_d(5'b00000, 3'b010, 32'h7000, 32'h0, 32'h0, 1'b0);
        sena = 1'b1;
        tick();
        sena = 1'b0;
        tick();
        chk("rm_wait_dstl", 32'(dstl), 32'h1);
        srst = 1'b1;
        tick();
        srst = 1'b0; dwb_dti = 32'h00C0FFEE;
        #1;
        chk("rm_stb",  {30'h0, dwb_cyc, dwb_stb}, 32'h0);
        chk("rm_xstb", 32'(xstb), 32'h3);
        chk("rm_xopc", 32'(xopc), 32'h04);
        chk("rm_dtm",  dwb_dtm,   32'h00C0FFEE);

        // reset while parked in DONE discards the captured word
        set_d(5'b00000, 3'b010, 32'h7000, 32'h0, 32'h0, 1'b0);
        sena = 1'b1;
        tick();
        sena = 1'b0; dwb_ack = 1'b1; dwb_dti = 32'h11111111;
        tick();
        dwb_ack = 1'b0; srst = 1'b1;
        tick();
        srst = 1'b0; dwb_dti = 32'h22222222;
        #1;
        chk("rd_dtm", dwb_dtm, 32'h22222222);
        chk("rd_stb", 32'(dwb_stb), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
